mem_port_arbiter: RTL and testbench

Shares the single-port 256×64 main data memory between two requesters in the processor: the instruction-fetch port (read-only) and the data-memory-stage port (read/write). Each cycle it grants at most one request and drives the memory control signals. It returns read data and a completion pulse to the winner one cycle later. It flags out-of-range addresses instead of accessing the array.

---
 rtl/mem_pkg.sv | 7 +
 rtl/mem_port_arbiter.sv | 74 +++++++
 tb/tb_mem_port_arbiter.sv | 138 +++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// mem_pkg: shared memory geometry and arbiter owner encoding
package mem_pkg;
  localparam int MEM_WORDS = 256;
  localparam int MEM_AW = 8;
  localparam int WORD_W = 64;
  typedef enum logic [1:0] {OWN_NONE, OWN_FETCH, OWN_DATA} owner_e;
endpackage

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: fetch/data arbitration onto the single-port data memory
// MEM_ARB_STARVE_GUARD_EN adds a fetch starvation guard limited by STARVE_LIMIT
module mem_port_arbiter
  import mem_pkg::*;
#(
  parameter logic [WORD_W-1:0] ADDR_LIMIT = 64'd255,
  parameter int STARVE_LIMIT = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic [WORD_W-1:0] i_addr,
  output logic              i_gnt,
  output logic              i_done,
  output logic [WORD_W-1:0] i_rdata,
  output logic              i_err,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [WORD_W-1:0] d_addr,
  input  logic [WORD_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_done,
  output logic [WORD_W-1:0] d_rdata,
  output logic              d_err,
  output logic              mem_en,
  output logic              mem_we,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  input  logic [WORD_W-1:0] mem_rdata
);
  owner_e own_q, own_d;
  logic rd_q, rd_d, err_q, err_d;
  logic i_ok, d_ok, force_i, rd_ok;
  assign i_ok = i_addr <= ADDR_LIMIT;
  assign d_ok = d_addr <= ADDR_LIMIT;
`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam int CW = ($clog2(STARVE_LIMIT + 1) < 2) ? 2 : $clog2(STARVE_LIMIT + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  assign force_i = i_req && (cnt_q == CW'(STARVE_LIMIT));
  // Counts data grants only while fetch is actually waiting
  assign cnt_d = (i_gnt || !i_req) ? '0 : d_gnt ? cnt_q + CW'(1) : cnt_q;
  always_ff @(posedge clk) cnt_q <= reset ? '0 : cnt_d;
`else
  logic unused_starve;
  assign unused_starve = ^STARVE_LIMIT;
  assign force_i = 1'b0;
`endif
  always_comb begin
    d_gnt = !reset && d_req && !force_i;
    i_gnt = !reset && i_req && !d_gnt;
    mem_en = (d_gnt && d_ok) || (i_gnt && i_ok);
    mem_we = mem_en && d_gnt && d_we;
    mem_addr = !mem_en ? '0 : d_gnt ? d_addr[MEM_AW-1:0] : i_addr[MEM_AW-1:0];
    mem_wdata = (mem_en && d_gnt) ? d_wdata : '0;
    own_d = d_gnt ? OWN_DATA : i_gnt ? OWN_FETCH : OWN_NONE;
    rd_d = !(d_gnt && d_we);
    err_d = d_gnt ? !d_ok : (i_gnt && !i_ok);
  end
  always_ff @(posedge clk) begin
    own_q <= reset ? OWN_NONE : own_d;
    rd_q <= !reset && rd_d;
    err_q <= !reset && err_d;
  end
  // Reset in the completion cycle drops the access entirely
  always_comb begin
    rd_ok = rd_q && !err_q;
    i_done = !reset && own_q == OWN_FETCH;
    d_done = !reset && own_q == OWN_DATA;
    i_err = i_done && err_q;
    d_err = d_done && err_q;
    i_rdata = (i_done && rd_ok) ? mem_rdata : '0;
    d_rdata = (d_done && rd_ok) ? mem_rdata : '0;
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed checks of arbitration, completion, errors and reset
module tb_mem_port_arbiter;
  import mem_pkg::*;
`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif
  logic clk = 0, reset = 1;
  logic i_req = 0, d_req = 0, d_we = 0;
  logic [63:0] i_addr = 0, d_addr = 0, d_wdata = 0;
  logic i_gnt, i_done, i_err, d_gnt, d_done, d_err, mem_en, mem_we;
  logic [63:0] i_rdata, d_rdata, mem_wdata, mem_rdata;
  logic [7:0] mem_addr;
  logic [63:0] mem [MEM_WORDS];
  int checks = 0, errors = 0;

  mem_port_arbiter dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_done(i_done), .i_rdata(i_rdata), .i_err(i_err),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_gnt(d_gnt), .d_done(d_done),
    .d_rdata(d_rdata), .d_err(d_err), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  initial for (int i = 0; i < MEM_WORDS; i++) mem[i] = 64'h1000 + 64'(i);
  always @(posedge clk) if (mem_en) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem[mem_addr];
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    tick();
    tick();
    chk("rst_gnt", {i_gnt, d_gnt}, 0);
    chk("rst_done", {i_done, d_done, i_err, d_err}, 0);
    chk("rst_rdata", i_rdata | d_rdata, 0);
    chk("rst_mem", {mem_en, mem_we, mem_addr}, 0);
    chk("rst_wdata", mem_wdata, 0);
    reset = 0;
    d_req = 1; d_we = 1; d_addr = 5; d_wdata = 64'hDEAD;
    #1;
    chk("wr_gnt", {d_gnt, i_gnt}, 2'b10);
    chk("wr_mem", {mem_en, mem_we, mem_addr}, {2'b11, 8'd5});
    chk("wr_wdata", mem_wdata, 64'hDEAD);
    tick();
    chk("wr_done", {d_done, d_err, i_done}, 3'b100);
    chk("wr_rdata", d_rdata, 0);
    d_we = 0;
    #1;
    chk("rd_mem", {d_gnt, mem_en, mem_we, mem_addr}, {3'b110, 8'd5});
    tick();
    chk("rd_done", {d_done, d_err}, 2'b10);
    chk("rd_data", d_rdata, 64'hDEAD);
    d_req = 0;
    #1;
    chk("idle_mem", {d_gnt, i_gnt, mem_en, mem_addr}, 0);
    tick();
    chk("idle_done", {d_done, i_done}, 0);
    i_req = 1; i_addr = 7; d_req = 1; d_addr = 10;
    #1;
    chk("cont_gnt", {d_gnt, i_gnt}, 2'b10);
    chk("cont_addr", mem_addr, 10);
    tick();
    chk("cont_ddone", {d_done, i_done}, 2'b10);
    chk("cont_drdata", d_rdata, 64'h100A);
    chk("cont_irdata", i_rdata, 0);
    d_req = 0;
    #1;
    chk("cont_ignt", {d_gnt, i_gnt, mem_en, mem_we}, 4'b0110);
    chk("cont_iaddr", mem_addr, 7);
    tick();
    chk("cont_idone", {i_done, i_err, d_done}, 3'b100);
    chk("cont_idata", i_rdata, 64'h1007);
    i_req = 0; d_req = 1; d_addr = 256;
    #1;
    chk("oor_gnt", {d_gnt, mem_en, mem_we}, 3'b100);
    tick();
    chk("oor_done", {d_done, d_err}, 2'b11);
    chk("oor_rdata", d_rdata, 0);
    d_we = 1; d_addr = 20; d_wdata = 64'hBEEF;
    tick();
    chk("b2b_wdone", {d_done, d_err}, 2'b10);
    d_we = 0;
    tick();
    chk("b2b_rdata", d_rdata, 64'hBEEF);
    d_req = 0;
    i_addr = 300; i_req = 1;
    #1;
    chk("ioor_gnt", {i_gnt, mem_en}, 2'b10);
    tick();
    chk("ioor_done", {i_done, i_err, i_rdata == 0}, 3'b111);
    i_req = 0;
    tick();
    d_req = 1; d_addr = 1; i_req = 1; i_addr = 2;
    for (int k = 0; k < 8; k++) begin
      #1;
      chk($sformatf("starve_%0d", k), {d_gnt, i_gnt}, (GUARD && k % 4 == 3) ? 2'b01 : 2'b10);
      tick();
    end
    d_req = 0; i_req = 0;
    tick();
    d_req = 1; d_we = 0; d_addr = 5;
    #1;
    chk("mid_gnt", d_gnt, 1);
    tick();
    reset = 1;
    #1;
    chk("mid_suppr", {d_done, d_gnt, d_err, mem_en}, 0);
    chk("mid_rdata", d_rdata, 0);
    tick();
    reset = 0;
    #1;
    chk("mid_regnt", d_gnt, 1);
    tick();
    chk("mid_done", d_done, 1);
    chk("mid_data", d_rdata, 64'hDEAD);
    d_req = 0;
    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
